// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller for the RV32 ALU: decodes ALU control, registers operands,
// captures the ALU result/zero flag, resolves beq/bne and returns a valid/ready response.
module alu_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             is_rtype,
    input  logic             alu_src,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  alu_A,
    output logic [XLEN-1:0]  alu_B,
    output logic [3:0]       alu_ctrl,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_zero,
    output logic             rsp_taken,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              accept_s;
    logic              capture_s;
    logic              done_s;
    logic              taken_s;
    logic [4:0]        dec_s;

    logic [XLEN-1:0]   alu_a_r;
    logic [XLEN-1:0]   alu_b_r;
    logic [3:0]        alu_ctrl_r;
    logic [1:0]        op_r;
    logic [2:0]        funct3_r;
    logic              illegal_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [XLEN-1:0]   rsp_result_r;
    logic              rsp_zero_r;
    logic              rsp_taken_r;
    logic              rsp_illegal_r;
    logic [CNT_W-1:0]  op_count_r;

    // Returns {illegal, alu_ctrl}; branch compares always run SUB so the zero flag is valid.
    function automatic logic [4:0] decode_op(input logic [1:0] op, input logic [2:0] f3,
                                             input logic f7, input logic rtype);
        logic [4:0] res;
        res = {1'b1, 4'b1111};
        case (op)
            2'b00: res = {1'b0, 4'b0010};
            2'b01: res = ((f3 == 3'b000) || (f3 == 3'b001)) ? {1'b0, 4'b0110} : {1'b1, 4'b0110};
            2'b10: begin
                case (f3)
                    3'b000:  res = (rtype && f7) ? {1'b0, 4'b0110} : {1'b0, 4'b0010};
                    3'b111:  res = {1'b0, 4'b0000};
                    3'b110:  res = {1'b0, 4'b0001};
                    default: res = {1'b1, 4'b1111};
                endcase
            end
            2'b11:   res = {1'b0, 4'b0011};
            default: res = {1'b1, 4'b1111};
        endcase
        return res;
    endfunction

    // Next-state logic and the per-phase strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                capture_s    = 1'b1;
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    done_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Instruction decode of the live request fields.
    always_comb begin
        dec_s = decode_op(ALUOp, funct3, funct7_5, is_rtype);
    end

    // Branch resolution from the captured op and the settled ALU zero flag.
    always_comb begin
        taken_s = 1'b0;
        if (op_r == 2'b01) begin
            if (funct3_r == 3'b000) begin
                taken_s = alu_zero;
            end else if (funct3_r == 3'b001) begin
                taken_s = ~alu_zero;
            end else begin
                taken_s = 1'b0;
            end
        end else begin
            taken_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand/control registers feeding the ALU; loaded only on accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a_r    <= {XLEN{1'b0}};
            alu_b_r    <= {XLEN{1'b0}};
            alu_ctrl_r <= 4'b1111;
            op_r       <= 2'b00;
            funct3_r   <= 3'b000;
            illegal_r  <= 1'b0;
        end else if (accept_s) begin
            alu_a_r    <= rs1_data;
            alu_b_r    <= alu_src ? imm : rs2_data;
            alu_ctrl_r <= dec_s[3:0];
            op_r       <= ALUOp;
            funct3_r   <= funct3;
            illegal_r  <= dec_s[4];
        end
    end

    // Response capture at the end of EXEC; illegal ops report a zero result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_result_r  <= {XLEN{1'b0}};
            rsp_zero_r    <= 1'b0;
            rsp_taken_r   <= 1'b0;
            rsp_illegal_r <= 1'b0;
        end else if (capture_s) begin
            rsp_result_r  <= illegal_r ? {XLEN{1'b0}} : alu_result;
            rsp_zero_r    <= alu_zero;
            rsp_taken_r   <= illegal_r ? 1'b0 : taken_s;
            rsp_illegal_r <= illegal_r;
        end
    end

    // Handshake flags registered from the next state so they line up with the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_next_s == ST_IDLE);
            rsp_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Saturating count of completed responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_count_r <= {CNT_W{1'b0}};
        end else if (done_s && (op_count_r != {CNT_W{1'b1}})) begin
            op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign req_ready   = req_ready_r;
    assign alu_A       = alu_a_r;
    assign alu_B       = alu_b_r;
    assign alu_ctrl    = alu_ctrl_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_zero    = rsp_zero_r;
    assign rsp_taken   = rsp_taken_r;
    assign rsp_illegal = rsp_illegal_r;
    assign op_count    = op_count_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed and random ops against a spec-level model,
// plus a narrow-counter instance that exercises op_count saturation.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic        is_rtype = 1'b0;
    logic        alu_src = 1'b0;
    logic [31:0] rs1_data = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [31:0] imm = 32'h0;
    logic        rsp_ready = 1'b0;

    logic        req_ready, rsp_valid, rsp_zero, rsp_taken, rsp_illegal;
    logic [31:0] alu_A, alu_B, rsp_result, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic [15:0] op_count;

    logic        s_req_ready, s_rsp_valid, s_rsp_zero, s_rsp_taken, s_rsp_illegal;
    logic [31:0] s_alu_A, s_alu_B, s_rsp_result, s_alu_result;
    logic [3:0]  s_alu_ctrl;
    logic        s_alu_zero;
    logic [2:0]  s_op_count;

    int tests = 0;
    int fails = 0;
    int cnt   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real one.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a;
            default: r = 32'hBADC0DE5;
        endcase
        return {(c == 4'b0110) && (r == 32'h0), r};
    endfunction

    always_comb {alu_zero, alu_result}     = alu_fn(alu_A, alu_B, alu_ctrl);
    always_comb {s_alu_zero, s_alu_result} = alu_fn(s_alu_A, s_alu_B, s_alu_ctrl);

    alu_issue_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .is_rtype(is_rtype),
        .alu_src(alu_src), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_taken(rsp_taken),
        .rsp_illegal(rsp_illegal), .op_count(op_count)
    );

    alu_issue_ctrl #(.XLEN(32), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .is_rtype(is_rtype),
        .alu_src(alu_src), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_A(s_alu_A), .alu_B(s_alu_B), .alu_ctrl(s_alu_ctrl), .alu_result(s_alu_result),
        .alu_zero(s_alu_zero), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_taken(s_rsp_taken),
        .rsp_illegal(s_rsp_illegal), .op_count(s_op_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(32'h0));
        chk("rst_rsp_flags", 64'({rsp_zero, rsp_taken, rsp_illegal}), 64'(3'b000));
        chk("rst_alu_A", 64'(alu_A), 64'(32'h0));
        chk("rst_alu_B", 64'(alu_B), 64'(32'h0));
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(4'b1111));
        chk("rst_op_count", 64'(op_count), 64'(16'h0));
        chk("rst_small_count", 64'(s_op_count), 64'(3'h0));
    endtask

    // Full operation: issue, watch EXEC and RESP, stall delay cycles, then hand off.
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic rt, input logic src, input logic [31:0] a,
                         input logic [31:0] b2, input logic [31:0] im, input int delay);
        logic [31:0] b, e_res;
        logic [3:0]  e_ctrl;
        logic        e_ill, e_zero, e_taken, is_sub;
        b      = src ? im : b2;
        e_ill  = (op == 2'd2 && !(f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7)) ||
                 (op == 2'd1 && f3 > 3'd1);
        is_sub = (op == 2'd1) || (op == 2'd2 && f3 == 3'd0 && rt && f7);
        if (op == 2'd2 && e_ill)      begin e_ctrl = 4'b1111; e_res = 32'h0;   end
        else if (op == 2'd3)          begin e_ctrl = 4'b0011; e_res = a;       end
        else if (is_sub)              begin e_ctrl = 4'b0110; e_res = a - b;   end
        else if (op == 2'd2 && f3 == 3'd7) begin e_ctrl = 4'b0000; e_res = a & b; end
        else if (op == 2'd2 && f3 == 3'd6) begin e_ctrl = 4'b0001; e_res = a | b; end
        else                          begin e_ctrl = 4'b0010; e_res = a + b;   end
        if (e_ill) e_res = 32'h0;
        e_zero  = is_sub && (a == b);
        e_taken = (op == 2'd1) && !e_ill && ((f3 == 3'd0) ? (a == b) : (a != b));

        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'(1'b1));
        ALUOp = op; funct3 = f3; funct7_5 = f7; is_rtype = rt; alu_src = src;
        rs1_data = a; rs2_data = b2; imm = im; req_valid = 1'b1;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("exec_req_ready", 64'(req_ready), 64'(1'b0));
        chk("exec_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("exec_alu_ctrl", 64'(alu_ctrl), 64'(e_ctrl));
        chk("exec_alu_A", 64'(alu_A), 64'(a));
        chk("exec_alu_B", 64'(alu_B), 64'(b));
        req_valid = 1'($urandom_range(0, 1));
        rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
        ALUOp = 2'($urandom_range(0, 3)); funct3 = 3'($urandom_range(0, 7));
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("resp_rsp_valid", 64'(rsp_valid), 64'(1'b1));
        chk("resp_result", 64'(rsp_result), 64'(e_res));
        chk("resp_flags", 64'({rsp_zero, rsp_taken, rsp_illegal}), 64'({e_zero, e_taken, e_ill}));
        chk("resp_alu_A_held", 64'(alu_A), 64'(a));
        chk("resp_count_unchanged", 64'(op_count), 64'(cnt > 65535 ? 65535 : cnt));
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 64'(rsp_valid), 64'(1'b1));
            chk("stall_req_ready", 64'(req_ready), 64'(1'b0));
            chk("stall_result", 64'(rsp_result), 64'(e_res));
            chk("stall_flags", 64'({rsp_zero, rsp_taken, rsp_illegal}), 64'({e_zero, e_taken, e_ill}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        cnt++;
        chk("done_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("done_req_ready", 64'(req_ready), 64'(1'b1));
        chk("done_op_count", 64'(op_count), 64'(cnt > 65535 ? 65535 : cnt));
        chk("done_small_count", 64'(s_op_count), 64'(cnt > 7 ? 7 : cnt));
        chk("done_result_held", 64'(rsp_result), 64'(e_res));
    endtask

    // Accept a request and pull reset in EXEC (phase 0) or RESP (phase 1).
    task automatic reset_mid(input int phase);
        @(negedge clk);
        ALUOp = 2'b11; funct3 = 3'b000; alu_src = 1'b0;
        rs1_data = 32'hCAFEF00D; rs2_data = 32'h1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (phase == 1) @(negedge clk);
        chk("pre_reset_busy", 64'(req_ready), 64'(1'b0));
        reset = 1'b0;
        @(negedge clk);
        cnt = 0;
        chk_reset_state();
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'(req_ready), 64'(1'b1));
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        reset = 1'b1;

        do_op(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'h0000000A, 32'h00000003, 32'h0, 0);
        do_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 32'h0, 1);
        do_op(2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 32'h0, 0);
        do_op(2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'h00000001, 32'h0, 0);
        do_op(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'h0, 32'h0000FFFF, 0);
        do_op(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'h0, 32'h0000FFFF, 0);
        do_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'h00000008, 32'h0, 32'h00000008, 0);
        do_op(2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 32'h00001000, 32'h0, 32'hFFFFFFFC, 5);
        do_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 0);
        do_op(2'b01, 3'b101, 1'b0, 1'b0, 1'b0, 32'h00000005, 32'h00000005, 32'h0, 0);
        do_op(2'b11, 3'b010, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 32'h00000004, 2);

        reset_mid(0);
        do_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h7, 32'h9, 32'h0, 0);
        reset_mid(1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b2;
            a  = $urandom;
            b2 = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b2, $urandom,
                  int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
